// File: rtl/fpu_pkg.sv
// Shared types and widths for the FPU result collection path.
package fpu_pkg;

  localparam int unsigned HALF_W    = 16;
  localparam int unsigned DATA_W    = 2 * HALF_W;
  localparam int unsigned EXC_W     = 3;
  // Widest sequence tag an entry can carry; collectors use the low TAG_W bits.
  localparam int unsigned TAG_W_MAX = 8;

  typedef enum logic [0:0] {
    COL_IDLE    = 1'b0,
    COL_WAIT_LO = 1'b1
  } col_state_t;

  typedef struct packed {
    logic [DATA_W-1:0]    data;
    logic [EXC_W-1:0]     exc;
    logic [TAG_W_MAX-1:0] tag;
  } result_entry_t;

endpackage

// File: rtl/fpu_result_fifo.sv
// Synchronous FIFO of result entries; head entry is visible without a pop.
module fpu_result_fifo
  import fpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  result_entry_t    wr_entry,
  output result_entry_t    head,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  result_entry_t    mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_entry;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/fpu_result_collector.sv
// Rebuilds two-beat FPU results into tagged 32-bit entries and queues them for the host.
module fpu_result_collector
  import fpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 4,
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic [HALF_W-1:0] DOUT,
  input  logic              DOV,
  input  logic [EXC_W-1:0]  EXC,
  output logic              DOA,
  output logic [DATA_W-1:0] RES_DATA,
  output logic [EXC_W-1:0]  RES_EXC,
  output logic [TAG_W-1:0]  RES_TAG,
  output logic              RES_VALID,
  input  logic              RES_READY,
  output logic [CNT_W-1:0]  COUNT,
  output logic              FULL,
  output logic              PROTO_ERR,
  input  logic              CLR_ERR
);

  col_state_t        state;
  col_state_t        state_nxt;
  logic [HALF_W-1:0] hi_reg;
  logic [TAG_W-1:0]  tag;
  logic              hi_load;
  logic              push;
  logic              err_set;
  logic              pop;
  logic              space;
  logic              empty;
  result_entry_t     wr_entry;
  result_entry_t     head;
  logic              unused_head_tag;

  assign pop   = RES_VALID & RES_READY;
  assign space = ~FULL | pop;

  // High beat is always captured; the low beat waits for FIFO space, and losing DOV there is an error.
  always_comb begin
    state_nxt = state;
    hi_load   = 1'b0;
    push      = 1'b0;
    err_set   = 1'b0;
    DOA       = 1'b0;
    case (state)
      COL_IDLE: begin
        if (DOV) begin
          hi_load   = 1'b1;
          state_nxt = COL_WAIT_LO;
        end
      end
      COL_WAIT_LO: begin
        if (!DOV) begin
          err_set   = 1'b1;
          state_nxt = COL_IDLE;
        end else if (space) begin
          DOA       = 1'b1;
          push      = 1'b1;
          state_nxt = COL_IDLE;
        end
      end
      default: state_nxt = COL_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state     <= COL_IDLE;
      tag       <= '0;
      PROTO_ERR <= 1'b0;
    end else begin
      state <= state_nxt;
      if (push) tag <= tag + TAG_W'(1);
      if (err_set)      PROTO_ERR <= 1'b1;
      else if (CLR_ERR) PROTO_ERR <= 1'b0;
    end
  end

  // Stale contents after reset are harmless: the state returns to IDLE.
  always_ff @(posedge CLK) begin
    if (hi_load) hi_reg <= DOUT;
  end

  assign wr_entry.data = {hi_reg, DOUT};
  assign wr_entry.exc  = EXC;
  assign wr_entry.tag  = TAG_W_MAX'(tag);

  fpu_result_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (CLK),
    .rst_n    (RSTn),
    .push     (push),
    .pop      (pop),
    .wr_entry (wr_entry),
    .head     (head),
    .empty    (empty),
    .full     (FULL),
    .count    (COUNT)
  );

  assign RES_VALID       = ~empty;
  assign RES_DATA        = head.data;
  assign RES_EXC         = head.exc;
  assign RES_TAG         = head.tag[TAG_W-1:0];
  assign unused_head_tag = ^head.tag;

endmodule
